capture_responder: RTL and testbench

Synthesizable responder for the capture-and-check assertion suite: the design side that the local-variable properties observe. It echoes each `valid`/`data` beat on `out_valid`/`out_data` after a fixed latency. It also holds recent writes (`write_en`, `addr`, `data`) in a small aging table and answers `read_en` lookups within a bounded window. It sits under the SVA regression benches as the DUT whose outputs the properties check.

---
 rtl/capture_responder_pkg.sv | 39 +++
 rtl/echo_delay.sv | 42 ++++
 rtl/capture_responder.sv | 143 ++++++++++++++
 tb/tb_capture_responder.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/capture_responder_pkg.sv
// Shared defaults and helpers for the capture responder: parameter defaults
// and the oldest-entry picker used when the write table is full.
package capture_responder_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DEPTH  = 4;
    localparam int DEF_WINDOW = 5;
    localparam int DEF_LAT    = 1;

    // Upper bounds of the flattened age vector handed to pick_oldest.
    localparam int MAX_DEPTH = 16;
    localparam int MAX_AGE_W = 8;

    // Index of the entry with the largest age; ties resolve to the lowest index.
    function automatic logic [7:0] pick_oldest(
        input logic [MAX_DEPTH*MAX_AGE_W-1:0] ages,
        input int                             depth
    );
        logic [7:0]           best;
        logic [MAX_AGE_W-1:0] best_age;
        best     = 8'd0;
        best_age = ages[MAX_AGE_W-1:0];
        for (int i = 1; i < MAX_DEPTH; i++) begin
            if (i < depth) begin
                if (ages[i*MAX_AGE_W +: MAX_AGE_W] > best_age) begin
                    best     = 8'(i);
                    best_age = ages[i*MAX_AGE_W +: MAX_AGE_W];
                end else begin
                    best = best;
                end
            end else begin
                best = best;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/echo_delay.sv
// Fixed-latency echo of {valid, data}; a stage's payload only loads on a valid
// beat, so the last stage holds the most recently echoed value while idle.
module echo_delay #(
    parameter int LAT    = 1,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [LAT-1:0]    vld_r;
    logic [DATA_W-1:0] dat_r [LAT];

    // Shift pipeline; async clear drops any in-flight beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r <= '0;
            for (int i = 0; i < LAT; i++) begin
                dat_r[i] <= '0;
            end
        end else begin
            vld_r[0] <= in_valid;
            if (in_valid) begin
                dat_r[0] <= in_data;
            end
            for (int i = 1; i < LAT; i++) begin
                vld_r[i] <= vld_r[i-1];
                if (vld_r[i-1]) begin
                    dat_r[i] <= dat_r[i-1];
                end
            end
        end
    end

    assign out_valid = vld_r[LAT-1];
    assign out_data  = dat_r[LAT-1];

endmodule

// File: rtl/capture_responder.sv
// Echo pipeline plus a small aging write table answering reads one cycle later.
// Reads see the table as it stood at the start of the cycle (no write bypass).
module capture_responder
    import capture_responder_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int WINDOW = DEF_WINDOW,
    parameter int LAT    = DEF_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              write_en,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] addr,
    output logic              rd_valid,
    output logic              rd_hit,
    output logic [DATA_W-1:0] rd_data
);

    localparam int AGE_W = $clog2(WINDOW + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // age counts cycles since the write, starting at 0 on the following cycle.
    typedef struct packed {
        logic              live;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [AGE_W-1:0]  age;
    } entry_t;

    entry_t tbl_r      [DEPTH];
    entry_t tbl_next_s [DEPTH];

    logic [DEPTH-1:0]               match_s;
    logic [DEPTH-1:0]               free_s;
    logic                           any_match_s;
    logic                           any_free_s;
    logic [IDX_W-1:0]               match_idx_s;
    logic [IDX_W-1:0]               free_idx_s;
    logic [IDX_W-1:0]               victim_idx_s;
    logic [IDX_W-1:0]               wr_idx_s;
    logic [DATA_W-1:0]              hit_data_s;
    logic [MAX_DEPTH*MAX_AGE_W-1:0] ages_flat_s;

    echo_delay #(.LAT(LAT), .DATA_W(DATA_W)) u_echo (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (valid),
        .in_data  (data),
        .out_valid(out_valid),
        .out_data (out_data)
    );

    // Address match, free-slot search and write-slot selection.
    always_comb begin
        match_s     = '0;
        free_s      = '0;
        hit_data_s  = '0;
        match_idx_s = '0;
        free_idx_s  = '0;
        ages_flat_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_s[i] = tbl_r[i].live && (tbl_r[i].addr == addr);
            free_s[i]  = !tbl_r[i].live;
            ages_flat_s[i*MAX_AGE_W +: MAX_AGE_W] = MAX_AGE_W'(tbl_r[i].age);
            if (match_s[i]) begin
                hit_data_s  = hit_data_s | tbl_r[i].data;
                match_idx_s = IDX_W'(i);
            end else begin
                hit_data_s = hit_data_s;
            end
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (free_s[i]) begin
                free_idx_s = IDX_W'(i);
            end else begin
                free_idx_s = free_idx_s;
            end
        end
        any_match_s  = |match_s;
        any_free_s   = |free_s;
        victim_idx_s = IDX_W'(pick_oldest(ages_flat_s, DEPTH));
        if (any_match_s) begin
            wr_idx_s = match_idx_s;
        end else if (any_free_s) begin
            wr_idx_s = free_idx_s;
        end else begin
            wr_idx_s = victim_idx_s;
        end
    end

    // Per-entry next state: write, age or expire.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            tbl_next_s[i] = tbl_r[i];
            if (write_en && (wr_idx_s == IDX_W'(i))) begin
                tbl_next_s[i].live = 1'b1;
                tbl_next_s[i].addr = addr;
                tbl_next_s[i].data = data;
                tbl_next_s[i].age  = '0;
            end else if (tbl_r[i].live) begin
                if (tbl_r[i].age == AGE_W'(WINDOW - 1)) begin
                    tbl_next_s[i] = '0;
                end else begin
                    tbl_next_s[i].age = tbl_r[i].age + AGE_W'(1);
                end
            end else begin
                tbl_next_s[i] = tbl_r[i];
            end
        end
    end

    // Table state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_r[i] <= '0;
            end
        end else begin
            tbl_r <= tbl_next_s;
        end
    end

    // Registered read response, zeroed when no read was issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_hit   <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= read_en;
            rd_hit   <= read_en && any_match_s;
            rd_data  <= (read_en && any_match_s) ? hit_data_s : '0;
        end
    end

endmodule

// File: tb/tb_capture_responder.sv
// Directed vector table for the LAT=1 instance plus hand sequences for LAT=3
// echo timing and an asynchronous reset taken mid-stream.
module tb_capture_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [7:0]  data;
    logic        write_en;
    logic        read_en;
    logic [15:0] addr;

    logic        ov1, rv1, rh1;
    logic [7:0]  od1, rd1;
    logic        ov3, rv3, rh3;
    logic [7:0]  od3, rd3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    capture_responder #(.DATA_W(8), .ADDR_W(16), .DEPTH(4), .WINDOW(5), .LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .data(data),
        .out_valid(ov1), .out_data(od1), .write_en(write_en), .read_en(read_en),
        .addr(addr), .rd_valid(rv1), .rd_hit(rh1), .rd_data(rd1)
    );

    capture_responder #(.DATA_W(8), .ADDR_W(16), .DEPTH(4), .WINDOW(5), .LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .valid(valid), .data(data),
        .out_valid(ov3), .out_data(od3), .write_en(write_en), .read_en(read_en),
        .addr(addr), .rd_valid(rv3), .rd_hit(rh3), .rd_data(rd3)
    );

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        we;
        logic        re;
        logic [15:0] a;
        logic        e_ov;
        logic [7:0]  e_od;
        logic        e_rv;
        logic        e_hit;
        logic [7:0]  e_rd;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic we, input logic re,
                       input logic [15:0] a, input logic e_ov, input logic [7:0] e_od,
                       input logic e_rv, input logic e_hit, input logic [7:0] e_rd);
        vec_t x;
        x = '{v: v, d: d, we: we, re: re, a: a, e_ov: e_ov, e_od: e_od,
              e_rv: e_rv, e_hit: e_hit, e_rd: e_rd};
        vecs.push_back(x);
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic we, input logic re,
                        input logic [15:0] a);
        @(negedge clk);
        valid = v; data = d; write_en = we; read_en = re; addr = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; data = 8'h00; write_en = 1'b0; read_en = 1'b0; addr = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", -1, {31'd0, ov1}, 32'd0);
        chk("reset_out_data",  -1, {24'd0, od1}, 32'd0);
        chk("reset_rd_valid",  -1, {31'd0, rv1}, 32'd0);
        chk("reset_rd_hit",    -1, {31'd0, rh1}, 32'd0);
        chk("reset_rd_data",   -1, {24'd0, rd1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //   v     d      we    re    addr       ov    od     rv    hit   rd
        add(1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00); // 0
        add(1'b1, 8'hA5, 1'b0, 1'b0, 16'h0000, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00); // 1 echo
        add(1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00); // 2 hold
        add(1'b1, 8'h3C, 1'b0, 1'b0, 16'h0000, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h00); // 3
        add(1'b1, 8'h7E, 1'b0, 1'b0, 16'h0000, 1'b1, 8'h7E, 1'b0, 1'b0, 8'h00); // 4 back-to-back
        add(1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h7E, 1'b0, 1'b0, 8'h00); // 5
        add(1'b0, 8'h5C, 1'b1, 1'b0, 16'h1234, 1'b0, 8'h7E, 1'b0, 1'b0, 8'h00); // 6 write T
        add(1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h7E, 1'b0, 1'b0, 8'h00); // 7
        add(1'b0, 8'h00, 1'b0, 1'b1, 16'h1234, 1'b0, 8'h7E, 1'b1, 1'b1, 8'h5C); // 8 T+2 hit
        add(1'b0, 8'h00, 1'b0, 1'b1, 16'h1234, 1'b0, 8'h7E, 1'b1, 1'b1, 8'h5C); // 9
        add(1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h7E, 1'b0, 1'b0, 8'h00); // 10
        add(1'b0, 8'h00, 1'b0, 1'b1, 16'h1234, 1'b0, 8'h7E, 1'b1, 1'b1, 8'h5C); // 11 T+5 hit
        add(1'b0, 8'h00, 1'b0, 1'b1, 16'h1234, 1'b0, 8'h7E, 1'b1, 1'b0, 8'h00); // 12 T+6 miss
        add(1'b0, 8'h99, 1'b1, 1'b1, 16'h0042, 1'b0, 8'h7E, 1'b1, 1'b0, 8'h00); // 13 wr+rd same
        add(1'b0, 8'h00, 1'b0, 1'b1, 16'h0042, 1'b0, 8'h7E, 1'b1, 1'b1, 8'h99); // 14
        add(1'b0, 8'h11, 1'b1, 1'b0, 16'h0001, 1'b0, 8'h7E, 1'b0, 1'b0, 8'h00); // 15
        add(1'b0, 8'h12, 1'b1, 1'b0, 16'h0002, 1'b0, 8'h7E, 1'b0, 1'b0, 8'h00); // 16
        add(1'b0, 8'h13, 1'b1, 1'b0, 16'h0003, 1'b0, 8'h7E, 1'b0, 1'b0, 8'h00); // 17
        add(1'b0, 8'h14, 1'b1, 1'b0, 16'h0004, 1'b0, 8'h7E, 1'b0, 1'b0, 8'h00); // 18 evicts 0042
        add(1'b0, 8'h15, 1'b1, 1'b0, 16'h0005, 1'b0, 8'h7E, 1'b0, 1'b0, 8'h00); // 19 evicts 0001
        add(1'b0, 8'h00, 1'b0, 1'b1, 16'h0001, 1'b0, 8'h7E, 1'b1, 1'b0, 8'h00); // 20 miss
        add(1'b0, 8'h00, 1'b0, 1'b1, 16'h0002, 1'b0, 8'h7E, 1'b1, 1'b1, 8'h12); // 21
        add(1'b0, 8'h00, 1'b0, 1'b1, 16'h0005, 1'b0, 8'h7E, 1'b1, 1'b1, 8'h15); // 22
        add(1'b0, 8'h00, 1'b0, 1'b1, 16'h0004, 1'b0, 8'h7E, 1'b1, 1'b1, 8'h14); // 23
        add(1'b0, 8'h00, 1'b0, 1'b1, 16'h0003, 1'b0, 8'h7E, 1'b1, 1'b0, 8'h00); // 24 expired
        add(1'b0, 8'h11, 1'b1, 1'b0, 16'h0077, 1'b0, 8'h7E, 1'b0, 1'b0, 8'h00); // 25 write T
        add(1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h7E, 1'b0, 1'b0, 8'h00); // 26
        add(1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h7E, 1'b0, 1'b0, 8'h00); // 27
        add(1'b0, 8'h22, 1'b1, 1'b0, 16'h0077, 1'b0, 8'h7E, 1'b0, 1'b0, 8'h00); // 28 rewrite T+3
        add(1'b0, 8'h00, 1'b0, 1'b1, 16'h0077, 1'b0, 8'h7E, 1'b1, 1'b1, 8'h22); // 29 single copy
        add(1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h7E, 1'b0, 1'b0, 8'h00); // 30
        add(1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h7E, 1'b0, 1'b0, 8'h00); // 31
        add(1'b0, 8'h00, 1'b0, 1'b1, 16'h0077, 1'b0, 8'h7E, 1'b1, 1'b1, 8'h22); // 32 T+7
        add(1'b0, 8'h00, 1'b0, 1'b1, 16'h0077, 1'b0, 8'h7E, 1'b1, 1'b1, 8'h22); // 33 T+8
        add(1'b0, 8'h00, 1'b0, 1'b1, 16'h0077, 1'b0, 8'h7E, 1'b1, 1'b0, 8'h00); // 34 T+9

        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].d, vecs[i].we, vecs[i].re, vecs[i].a);
            chk("out_valid", i, {31'd0, ov1}, {31'd0, vecs[i].e_ov});
            chk("out_data",  i, {24'd0, od1}, {24'd0, vecs[i].e_od});
            chk("rd_valid",  i, {31'd0, rv1}, {31'd0, vecs[i].e_rv});
            chk("rd_hit",    i, {31'd0, rh1}, {31'd0, vecs[i].e_hit});
            chk("rd_data",   i, {24'd0, rd1}, {24'd0, vecs[i].e_rd});
        end

        // LAT=3 echo: beat driven in one cycle appears three cycles later.
        step(1'b1, 8'hC3, 1'b0, 1'b0, 16'h0000);
        chk("lat3_valid_c1", 100, {31'd0, ov3}, 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 16'h0000);
        chk("lat3_valid_c2", 101, {31'd0, ov3}, 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 16'h0000);
        chk("lat3_valid_c3", 102, {31'd0, ov3}, 32'd1);
        chk("lat3_data_c3",  102, {24'd0, od3}, 32'hC3);
        step(1'b0, 8'h00, 1'b0, 1'b0, 16'h0000);
        chk("lat3_valid_c4", 103, {31'd0, ov3}, 32'd0);
        chk("lat3_hold_c4",  103, {24'd0, od3}, 32'hC3);

        // Reset while a LAT=3 beat and a read are in flight.
        step(1'b0, 8'h66, 1'b1, 1'b0, 16'h00AB);
        step(1'b1, 8'h5A, 1'b0, 1'b1, 16'h00AB);
        chk("pre_rst_rd_hit", 110, {31'd0, rh3}, 32'd1);
        chk("pre_rst_rd_data", 110, {24'd0, rd3}, 32'h66);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid3", 111, {31'd0, ov3}, 32'd0);
        chk("rst_out_data3",  111, {24'd0, od3}, 32'd0);
        chk("rst_out_data1",  111, {24'd0, od1}, 32'd0);
        chk("rst_rd_valid",   111, {31'd0, rv3}, 32'd0);
        chk("rst_rd_hit",     111, {31'd0, rh3}, 32'd0);
        chk("rst_rd_data",    111, {24'd0, rd3}, 32'd0);
        @(negedge clk);
        valid = 1'b0; write_en = 1'b0; read_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0, 16'h0000);
            chk("post_rst_no_beat", 120 + k, {31'd0, ov3}, 32'd0);
            chk("post_rst_no_resp", 120 + k, {31'd0, rv3}, 32'd0);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1, 16'h00AB);
        chk("post_rst_rd_valid", 130, {31'd0, rv3}, 32'd1);
        chk("post_rst_rd_miss",  130, {31'd0, rh3}, 32'd0);
        chk("post_rst_rd_data",  130, {24'd0, rd3}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
